// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: instruction width, HLT opcode,
// NOP word, fetch FSM states and the IF/ID register payload.
package cpu_pkg;
  localparam int               INSTR_W   = 16;
  localparam logic [3:0]       OPC_HLT   = 4'hF;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus2;
    logic               valid;
  } ifid_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with async active-low reset; next PC is hold, branch target or PC+2.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               load,
  input  logic [INSTR_W-1:0] target,
  output logic [INSTR_W-1:0] pc
);
  logic [INSTR_W-1:0] pc_nxt;

  // PC+2 wraps modulo 2^16; target bit 0 is taken as-is.
  always_comb begin
    pc_nxt = pc + 16'd2;
    if (hold)      pc_nxt = pc;
    else if (load) pc_nxt = target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_nxt;
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: stall/branch/HLT handling with a RUN/HALTED FSM.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter logic [3:0]  OPC_HLT   = cpu_pkg::OPC_HLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt,
`endif
  output logic        halted
);
  fetch_state_e state, state_nxt;
  ifid_t        ifid_q, ifid_nxt;
  logic         pc_hold, pc_load;
  logic [15:0]  pc, pc_plus2;
  logic         is_hlt;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .hold   (pc_hold),
    .load   (pc_load),
    .target (branch_target),
    .pc     (pc)
  );

  assign imem_addr = pc;
  assign pc_plus2  = pc + 16'd2;
  assign is_hlt    = (imem_data[15:12] == OPC_HLT);

  always_comb begin
    pc_hold   = 1'b1;
    pc_load   = 1'b0;
    ifid_nxt  = ifid_q;
    state_nxt = state;
    if (!stall) begin
      if (state == RUN) begin
        if (branch_taken) begin
          // squash the wrong-path word even when it is an HLT
          pc_hold           = 1'b0;
          pc_load           = 1'b1;
          ifid_nxt.instr    = NOP_INSTR;
          ifid_nxt.pc_plus2 = 16'h0000;
          ifid_nxt.valid    = 1'b0;
        end else begin
          pc_hold           = is_hlt;
          ifid_nxt.instr    = imem_data;
          ifid_nxt.pc_plus2 = pc_plus2;
          ifid_nxt.valid    = 1'b1;
          if (is_hlt) state_nxt = HALTED;
        end
      end else begin
        ifid_nxt.instr    = NOP_INSTR;
        ifid_nxt.pc_plus2 = 16'h0000;
        ifid_nxt.valid    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RUN;
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc_plus2 <= 16'h0000;
      ifid_q.valid    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ifid_q <= ifid_nxt;
    end
  end

  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus2 = ifid_q.pc_plus2;
  assign ifid_valid    = ifid_q.valid;
  assign halted        = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
  // Both counters only advance while running and stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= 16'h0000;
      perf_flush_cnt <= 16'h0000;
    end else if (state == RUN) begin
      if (stall && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (branch_taken && !stall && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, random run vs. model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_data;
  logic [15:0] imem_addr, ifid_instr, ifid_pc_plus2;
  logic        ifid_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  logic [15:0] mem [256];
  int tests = 0;
  int fails = 0;

  assign imem_data = mem[imem_addr[8:1]];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br;
    logic [15:0] tgt, addr, instr, pp2;
    logic        valid, halt;
  } vec_t;
  vec_t vt[15];

  // behavioural reference state
  logic [15:0] m_pc, m_instr, m_pp2;
  logic        m_valid, m_halt;

  function automatic vec_t mk(logic s, logic b, logic [15:0] t, logic [15:0] a,
                              logic [15:0] i, logic [15:0] p, logic v, logic h);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.addr = a;
    r.instr = i; r.pp2 = p; r.valid = v; r.halt = h;
    return r;
  endfunction

  function automatic logic [7:0] idx(logic [15:0] a);
    return a[8:1];
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [15:0] a, logic [15:0] i, logic [15:0] p,
                         logic v, logic h);
    chk({tag, ".addr"}, imem_addr, a);
    chk({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, v});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, h});
    chk({tag, ".instr"}, ifid_instr, i);
    if (v) chk({tag, ".pc_plus2"}, ifid_pc_plus2, p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(logic s, logic b, logic [15:0] t);
    stall = s; branch_taken = b; branch_target = t;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  // One clock edge applied to the reference, written straight from the fetch rules.
  task automatic model_edge(logic s, logic b, logic [15:0] t);
    logic [15:0] w;
    w = mem[idx(m_pc)];
    if (s) return;
    if (m_halt) begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end else if (b) begin
      m_pc = t; m_instr = 16'h0000; m_valid = 1'b0;
    end else begin
      m_instr = w; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
      if (w[15:12] == 4'hF) m_halt = 1'b1;
      else                  m_pc = m_pc + 16'd2;
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0100 + 16'(k);
    mem[idx(16'h0000)] = 16'h1234;
    mem[idx(16'h0002)] = 16'h5678;
    mem[idx(16'h0004)] = 16'h1111;
    mem[idx(16'h0006)] = 16'h2222;
    mem[idx(16'h0008)] = 16'h3333;
    mem[idx(16'h000A)] = 16'h4444;
    mem[idx(16'h0020)] = 16'hF000;
    mem[idx(16'h0030)] = 16'hF123;
    mem[idx(16'h0040)] = 16'h5555;
    mem[idx(16'hFFFE)] = 16'h7777;

    //          stall br  tgt       addr      instr     pp2       v  h
    vt[0]  = mk(0, 0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1, 0);
    vt[1]  = mk(0, 0, 16'h0000, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    vt[2]  = mk(0, 0, 16'h0000, 16'h0006, 16'h1111, 16'h0006, 1, 0);
    vt[3]  = mk(1, 0, 16'h0000, 16'h0006, 16'h1111, 16'h0006, 1, 0);
    vt[4]  = mk(1, 0, 16'h0000, 16'h0006, 16'h1111, 16'h0006, 1, 0);
    vt[5]  = mk(1, 0, 16'h0000, 16'h0006, 16'h1111, 16'h0006, 1, 0);
    vt[6]  = mk(0, 0, 16'h0000, 16'h0008, 16'h2222, 16'h0008, 1, 0);
    vt[7]  = mk(0, 0, 16'h0000, 16'h000A, 16'h3333, 16'h000A, 1, 0);
    vt[8]  = mk(0, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0);
    vt[9]  = mk(1, 1, 16'h0080, 16'h0040, 16'h0000, 16'h0000, 0, 0);
    vt[10] = mk(0, 1, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 0, 0);
    vt[11] = mk(0, 0, 16'h0000, 16'h0020, 16'hF000, 16'h0022, 1, 1);
    vt[12] = mk(0, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 0, 1);
    vt[13] = mk(0, 1, 16'h0040, 16'h0020, 16'h0000, 16'h0000, 0, 1);
    vt[14] = mk(1, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 0, 1);

    #2;
    chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("reset.pc_plus2", ifid_pc_plus2, 16'h0000);
    #1 rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vt[i].stall, vt[i].br, vt[i].tgt);
      chk_all($sformatf("vec%0d", i), vt[i].addr, vt[i].instr, vt[i].pp2,
              vt[i].valid, vt[i].halt);
    end

    // async reset while halted
    rst = 1'b0;
    #1;
    chk_all("rst_halted", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1 rst = 1'b1;

    // HLT word in front of a taken branch must not halt
    step(0, 1, 16'h0030);
    chk_all("br_to_hlt", 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(0, 1, 16'h0040);
    chk_all("hlt_vs_br", 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(0, 0, 16'h0000);
    chk_all("after_br", 16'h0042, 16'h5555, 16'h0042, 1'b1, 1'b0);

    // PC+2 wraps from FFFE to 0000
    step(0, 1, 16'hFFFE);
    chk_all("br_fffe", 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(0, 0, 16'h0000);
    chk_all("wrap", 16'h0000, 16'h7777, 16'h0000, 1'b1, 1'b0);

    // random run against the reference model
    for (int k = 0; k < 256; k++)
      mem[k] = ($urandom_range(0, 99) < 4) ? 16'($urandom | 32'hF000)
                                             : 16'($urandom_range(0, 16'hEFFF));
    rst = 1'b0;
    #1;
    model_reset();
    #1 rst = 1'b1;
    begin
      int hcnt = 0;
      for (int c = 0; c < 600; c++) begin
        logic s, b;
        logic [15:0] t;
        s = ($urandom_range(0, 99) < 25);
        b = ($urandom_range(0, 99) < 15);
        t = 16'($urandom);
        model_edge(s, b, t);
        step(s, b, t);
        chk_all($sformatf("rnd%0d", c), m_pc, m_instr, m_pp2, m_valid, m_halt);
        hcnt = m_halt ? hcnt + 1 : 0;
        if (hcnt > 3) begin
          rst = 1'b0;
          #1;
          model_reset();
          #1 rst = 1'b1;
          hcnt = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
